// File: rtl/bp_pkg.sv
// Shared types, constants and helpers for the gshare branch predictor.
package bp_pkg;

    localparam int BP_PC_W      = 32;
    localparam int BP_CTR_W     = 2;
    localparam int BP_BTB_IDX_W = 4;
    localparam int SAT_W        = 16;

    typedef logic [BP_CTR_W-1:0] ctr_t;

    typedef struct packed {
        logic                              valid;
        logic [BP_PC_W-BP_BTB_IDX_W-3:0]   tag;
        logic [BP_PC_W-1:0]                target;
    } btb_entry_t;

    // Weakly-not-taken value for a counter of the given width.
    function automatic logic [SAT_W-1:0] ctr_reset_val(input int width);
        return SAT_W'((1 << (width - 1)) - 1);
    endfunction

    // Saturating increment/decrement for a counter of the given width.
    function automatic logic [SAT_W-1:0] sat_update(input logic [SAT_W-1:0] ctr,
                                                    input logic             inc,
                                                    input int               width);
        logic [SAT_W-1:0] max_val;
        max_val = SAT_W'((1 << width) - 1);
        if (inc) begin
            return (ctr == max_val) ? ctr : ctr + SAT_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - SAT_W'(1);
    endfunction

    localparam ctr_t CTR_WNT = ctr_t'(ctr_reset_val(BP_CTR_W));

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Predict and update bundle between fetch/execute and the gshare predictor.
interface gshare_branch_predictor_if #(
    parameter int PC_W      = 32,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8
);
    logic                 pred_req;
    logic [PC_W-1:0]      pred_pc;
    logic                 pred_vld;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pred_idx;
    logic [GHR_W-1:0]     pred_ghr;
    logic                 pred_hit;
    logic [PC_W-1:0]      pred_target;
    logic                 upd_vld;
    logic [PC_W-1:0]      upd_pc;
    logic [PHT_IDX_W-1:0] upd_idx;
    logic [GHR_W-1:0]     upd_ghr;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic [PC_W-1:0]      upd_target;

    modport master (
        output pred_req, pred_pc,
        output upd_vld, upd_pc, upd_idx, upd_ghr, upd_taken, upd_mispred, upd_target,
        input  pred_vld, pred_taken, pred_idx, pred_ghr, pred_hit, pred_target
    );

    modport slave (
        input  pred_req, pred_pc,
        input  upd_vld, upd_pc, upd_idx, upd_ghr, upd_taken, upd_mispred, upd_target,
        output pred_vld, pred_taken, pred_idx, pred_ghr, pred_hit, pred_target
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with a registered one-cycle lookup.
module bp_btb import bp_pkg::*; #(
    parameter int PC_W      = BP_PC_W,
    parameter int BTB_IDX_W = BP_BTB_IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [PC_W-1:0] rd_pc,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [PC_W-1:0] wr_target,
    output logic            hit,
    output logic [PC_W-1:0] target
);
    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = PC_W - BTB_IDX_W - 2;

    logic [ENTRIES-1:0]   valid;
    logic [TAG_W-1:0]     tags    [ENTRIES];
    logic [PC_W-1:0]      targets [ENTRIES];
    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic                 rd_match;
    logic                 unused_low_bits;

    assign unused_low_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    // Split lookup and write addresses into index and tag fields.
    always_comb begin
        rd_idx   = rd_pc[BTB_IDX_W+1:2];
        wr_idx   = wr_pc[BTB_IDX_W+1:2];
        rd_match = valid[rd_idx] && (tags[rd_idx] == rd_pc[PC_W-1:BTB_IDX_W+2]);
    end

    // Valid bits clear on reset; a taken branch allocates its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload; only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_pc[PC_W-1:BTB_IDX_W+2];
            targets[wr_idx] <= wr_target;
        end
    end

    // Registered lookup result, held between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit    <= 1'b0;
            target <= '0;
        end else if (rd_en) begin
            hit    <= rd_match;
            target <= rd_match ? targets[rd_idx] : '0;
        end
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: speculative GHR xor PC indexes a PHT of saturating
// counters; mispredicted updates repair the GHR. Optional BTB under BP_BTB_EN.
module gshare_branch_predictor import bp_pkg::*; #(
    parameter int PC_W      = BP_PC_W,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int CTR_W     = BP_CTR_W,
    parameter int BTB_IDX_W = BP_BTB_IDX_W
) (
    input logic                      clk,
    input logic                      rst_n,
    gshare_branch_predictor_if.slave bp
);
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam logic [CTR_W-1:0] WNT = (CTR_W == BP_CTR_W) ? CTR_W'(CTR_WNT)
                                                           : CTR_W'(ctr_reset_val(CTR_W));

    logic [CTR_W-1:0]     pht [PHT_N];
    logic [GHR_W-1:0]     ghr;
    logic [PHT_IDX_W-1:0] rd_idx;
    logic                 rd_taken;
    logic [CTR_W-1:0]     upd_ctr;
    logic                 repair;

    logic                 vld_q;
    logic                 taken_q;
    logic [PHT_IDX_W-1:0] idx_q;
    logic [GHR_W-1:0]     ghr_q;
    logic                 btb_hit;
    logic [PC_W-1:0]      btb_target;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{bp.pred_pc[PC_W-1:PHT_IDX_W+2], bp.pred_pc[1:0]};

    // Index, current counter direction and the counter's next value on update.
    always_comb begin
        rd_idx   = bp.pred_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
        rd_taken = pht[rd_idx][CTR_W-1];
        upd_ctr  = CTR_W'(sat_update(SAT_W'(pht[bp.upd_idx]), bp.upd_taken, CTR_W));
        repair   = bp.upd_vld & bp.upd_mispred;
    end

    // Pattern history table; the write lands after this cycle's read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= WNT;
            end
        end else if (bp.upd_vld) begin
            pht[bp.upd_idx] <= upd_ctr;
        end
    end

    // Global history: repair wins over the wrong-path speculative shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= GHR_W'({bp.upd_ghr, bp.upd_taken});
        end else if (bp.pred_req) begin
            ghr <= GHR_W'({ghr, rd_taken});
        end
    end

    // Registered prediction; valid pulses once per request, payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
            idx_q   <= '0;
            ghr_q   <= '0;
        end else begin
            vld_q <= bp.pred_req;
            if (bp.pred_req) begin
                taken_q <= rd_taken;
                idx_q   <= rd_idx;
                ghr_q   <= ghr;
            end
        end
    end

`ifdef BP_BTB_EN
    bp_btb #(
        .PC_W      (PC_W),
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (bp.pred_req),
        .rd_pc     (bp.pred_pc),
        .wr_en     (bp.upd_vld & bp.upd_taken),
        .wr_pc     (bp.upd_pc),
        .wr_target (bp.upd_target),
        .hit       (btb_hit),
        .target    (btb_target)
    );
`else
    logic unused_btb_inputs;
    assign unused_btb_inputs = ^{bp.upd_pc, bp.upd_target, BTB_IDX_W[0]};
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    assign bp.pred_vld    = vld_q;
    assign bp.pred_taken  = taken_q;
    assign bp.pred_idx    = idx_q;
    assign bp.pred_ghr    = ghr_q;
    assign bp.pred_hit    = btb_hit;
    assign bp.pred_target = btb_target;
endmodule
